// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage. Passes register-writing ALU results through to
// write-back and runs aligned OP_LW/OP_SW ops as a req/ack handshake on the dmem port.
// A misaligned load/store issues no memory request and raises a one-cycle err pulse.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, an ACCESS that receives
// no dmem_ack for TIMEOUT cycles is abandoned with an err pulse and no write-back.
module mem_stage #(
    parameter logic [5:0]  OP_LW   = 6'b001000,
    parameter logic [5:0]  OP_SW   = 6'b001010,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  alu_op,
    input  logic [4:0]  rd_addr,
    input  logic [31:0] ex_result,
    input  logic [31:0] data_addr,
    input  logic [31:0] store_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        err
);

    // A zero timeout would abandon every access before it could be acknowledged
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_stage: TIMEOUT must be at least 1");
    end

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_n;
    logic [5:0]  op_q, op_n;
    logic [4:0]  rd_q, rd_n;
    logic        dmem_req_n, dmem_we_n, wb_valid_n, err_n;
    logic [31:0] dmem_addr_n, dmem_wdata_n, wb_data_n;
    logic [4:0]  wb_rd_n;
    logic        accept;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt, cnt_n;
`endif

    // Ops that write a destination register
    function automatic logic writes_reg(input logic [5:0] op);
        case (op)
            6'b000001, 6'b000010, 6'b000011, 6'b000100,
            6'b000101, 6'b000110, 6'b000111, 6'b001001,
            6'b001110: writes_reg = 1'b1;
            default:   writes_reg = 1'b0;
        endcase
    endfunction

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // Next-state and next-output logic; memory outputs are held only while in ACCESS
    always_comb begin
        state_n      = state;
        op_n         = op_q;
        rd_n         = rd_q;
        dmem_req_n   = 1'b0;
        dmem_we_n    = 1'b0;
        dmem_addr_n  = 32'd0;
        dmem_wdata_n = 32'd0;
        wb_valid_n   = 1'b0;
        wb_rd_n      = 5'd0;
        wb_data_n    = 32'd0;
        err_n        = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_n        = cnt;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    op_n = alu_op;
                    rd_n = rd_addr;
                    if (alu_op == OP_LW || alu_op == OP_SW) begin
                        if (data_addr[1:0] != 2'b00) begin
                            err_n = 1'b1;
                        end else begin
                            state_n      = ACCESS;
                            dmem_req_n   = 1'b1;
                            dmem_we_n    = (alu_op == OP_SW);
                            dmem_addr_n  = data_addr;
                            dmem_wdata_n = (alu_op == OP_SW) ? store_data : 32'd0;
`ifdef MEM_TIMEOUT_EN
                            cnt_n        = CNT_W'(0);
`endif
                        end
                    end else if (writes_reg(alu_op) && rd_addr != 5'd0) begin
                        wb_valid_n = 1'b1;
                        wb_rd_n    = rd_addr;
                        wb_data_n  = ex_result;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    state_n = IDLE;
                    if (op_q == OP_LW && rd_q != 5'd0) begin
                        wb_valid_n = 1'b1;
                        wb_rd_n    = rd_q;
                        wb_data_n  = dmem_rdata;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n = IDLE;
                    err_n   = 1'b1;
                end
`endif
                else begin
                    dmem_req_n   = 1'b1;
                    dmem_we_n    = dmem_we;
                    dmem_addr_n  = dmem_addr;
                    dmem_wdata_n = dmem_wdata;
`ifdef MEM_TIMEOUT_EN
                    cnt_n        = cnt + CNT_W'(1);
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, latched op fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 6'd0;
            rd_q       <= 5'd0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_wdata <= 32'd0;
            wb_valid   <= 1'b0;
            wb_rd      <= 5'd0;
            wb_data    <= 32'd0;
            err        <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt        <= CNT_W'(0);
`endif
        end else begin
            state      <= state_n;
            op_q       <= op_n;
            rd_q       <= rd_n;
            dmem_req   <= dmem_req_n;
            dmem_we    <= dmem_we_n;
            dmem_addr  <= dmem_addr_n;
            dmem_wdata <= dmem_wdata_n;
            wb_valid   <= wb_valid_n;
            wb_rd      <= wb_rd_n;
            wb_data    <= wb_data_n;
            err        <= err_n;
`ifdef MEM_TIMEOUT_EN
            cnt        <= cnt_n;
`endif
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk only.
REQ-002 Parameter OP_LW, default 6'b001000, SHALL be the alu_op code for a load.
REQ-003 Parameter OP_SW, default 6'b001010, SHALL be the alu_op code for a store.
REQ-004 Parameter TIMEOUT, default 16, SHALL be the maximum number of cycles waited for dmem_ack; it is used only when MEM_TIMEOUT_EN is defined.
REQ-005 Ports:
  clk         in   1   clock
  rst         in   1   synchronous active-high reset
  in_valid    in   1   execute-stage result valid
  in_ready    out  1   stage can accept this cycle
  alu_op      in   6   operation code from execute
  rd_addr     in   5   destination register
  ex_result   in   32  execute ALU result
  data_addr   in   32  execute effective address
  store_data  in   32  rs2 data for store
  dmem_req    out  1   memory request
  dmem_we     out  1   1 = write, 0 = read
  dmem_addr   out  32  memory address
  dmem_wdata  out  32  memory write data
  dmem_ack    in   1   memory completion
  dmem_rdata  in   32  load data, valid with dmem_ack
  wb_valid    out  1   write-back pulse
  wb_rd       out  5   write-back register
  wb_data     out  32  write-back data
  err         out  1   one-cycle error pulse

Function
REQ-006 The FSM SHALL have two states: IDLE and ACCESS.
REQ-007 in_ready SHALL equal (state==IDLE) AND NOT rst; a transfer SHALL occur on a cycle where in_valid and in_ready are both 1.
REQ-008 On an accepted transfer, the block SHALL latch alu_op, rd_addr, ex_result, data_addr and store_data.
REQ-009 A non-memory op SHALL produce a write-back only when it writes a register and rd_addr is not 0; the writing ops are 6'b000001-6'b000111, 6'b001001 and 6'b001110.
REQ-010 For such an op, the block SHALL drive wb_valid=1, wb_rd=rd_addr and wb_data=ex_result in the cycle after acceptance, and SHALL remain in IDLE.
REQ-011 Ops 6'b000000, 6'b001011, 6'b001100, 6'b001101 and any unlisted code SHALL be accepted and SHALL produce no write-back and no error.
REQ-012 An accepted OP_LW or OP_SW with data_addr[1:0] != 0 SHALL issue no memory request, SHALL pulse err in the next cycle, and SHALL remain in IDLE.
REQ-013 An accepted aligned OP_LW or OP_SW SHALL move the FSM to ACCESS.
REQ-014 From the cycle after acceptance, dmem_req SHALL be 1 and dmem_addr, dmem_we and dmem_wdata SHALL hold stable until dmem_ack is sampled 1.
REQ-015 dmem_we SHALL be 1 for OP_SW and 0 for OP_LW; dmem_wdata SHALL equal store_data for OP_SW and 0 for OP_LW.
REQ-016 dmem_ack sampled 1 in ACCESS SHALL deassert dmem_req in the next cycle and return the FSM to IDLE.
REQ-017 For a load, that same cycle SHALL drive wb_valid=1 with wb_data equal to dmem_rdata captured at ack, provided rd_addr is not 0.
REQ-018 A store SHALL never assert wb_valid.
REQ-019 dmem_ack sampled while in IDLE SHALL be ignored.
REQ-020 Minimum memory-op occupancy SHALL be 2 cycles, with dmem_ack arriving in the first request cycle; back-to-back memory ops SHALL therefore accept every 2 cycles at best.
REQ-021 wb_valid and err SHALL each be single-cycle pulses; outside their pulse cycle, wb_rd and wb_data SHALL be 0.
REQ-022 Outside a pulse cycle, dmem_addr and dmem_wdata SHALL be 0 whenever dmem_req is 0.

Reset
REQ-023 rst SHALL force state IDLE and drive dmem_req, dmem_we, dmem_addr, dmem_wdata, wb_valid, wb_rd, wb_data and err to 0; in_ready SHALL be 0 while rst is high.
REQ-024 Reset asserted during ACCESS SHALL drop dmem_req at the next edge, discard the pending op and produce no write-back.
REQ-025 A dmem_ack arriving after a reset SHALL be ignored.

Configuration
REQ-026 With macro MEM_TIMEOUT_EN defined, a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ack.
REQ-027 With MEM_TIMEOUT_EN defined, when the count reaches TIMEOUT the block SHALL deassert dmem_req, return to IDLE, pulse err and produce no write-back.
REQ-028 Without MEM_TIMEOUT_EN, no counter SHALL exist, ACCESS SHALL wait indefinitely for dmem_ack, and err SHALL come only from misalignment.

Verification
REQ-029 ADD, rd=5, ex_result=0x0000_0007, accepted at cycle N -> wb_valid=1, wb_rd=5, wb_data=7 at N+1; dmem_req stays 0.
REQ-030 LW, rd=3, data_addr=0x100, ack at N+3 with rdata=0xDEAD_BEEF -> dmem_req=1 and dmem_addr=0x100 during N+1..N+3; in_ready=0; wb_data=0xDEAD_BEEF at N+4.
REQ-031 SW, data_addr=0x204, store_data=0x1234 -> dmem_we=1, dmem_wdata=0x1234; no wb_valid after ack.
REQ-032 LW with data_addr=0x102 -> err pulses at N+1; dmem_req stays 0; in_ready stays 1.
REQ-033 rst asserted mid-ACCESS, then dmem_ack pulsed after reset -> dmem_req=0 after the edge; no wb_valid; ack ignored.
REQ-034 MEM_TIMEOUT_EN defined, TIMEOUT=16, LW with no ack -> dmem_req drops and err pulses 16 cycles after ACCESS entry; FSM returns to IDLE.
